// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon-Hash controller.
// The pad byte and lane count follow Ascon v1.2 (64-bit rate, 256-bit digest).
package ascon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_PSTART,
    ST_WAIT,
    ST_ABSORB,
    ST_PAD,
    ST_SQUEEZE,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_ABS = 1'b0,
    PH_SQZ = 1'b1
  } phase_t;

  localparam logic [7:0] ASCON_PAD_BYTE   = 8'h80;
  localparam int         ASCON_TAG_LANES  = 4;
  localparam logic [3:0] ASCON_LANE_BYTES = 4'd8;

  // Byte counts above a full lane are treated as a full lane.
  function automatic logic [3:0] sat_bytes(input logic [3:0] n);
    return (n > ASCON_LANE_BYTES) ? ASCON_LANE_BYTES : n;
  endfunction

endpackage

// File: rtl/ascon_pad.sv
// Combinational Ascon v1.2 padding of the final message block.
// Byte 0 sits in the top byte; a full final block passes through untouched.
module ascon_pad
  import ascon_pkg::*;
#(
  parameter int BW = 64
) (
  input  logic [BW-1:0] msg_data,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  output logic [BW-1:0] dp_block
);

  logic [3:0] n_bytes;
  assign n_bytes = sat_bytes(msg_bytes);

  always_comb begin
    dp_block = msg_data;
    if (msg_last) begin
      for (int i = 0; i < BW / 8; i++) begin
        if (i == int'(n_bytes)) begin
          dp_block[BW-1-8*i -: 8] = ASCON_PAD_BYTE;
        end else if (i > int'(n_bytes)) begin
          dp_block[BW-1-8*i -: 8] = 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Sequences the Ascon-Hash datapath: IV load, absorb with padding, squeeze of four tag lanes.
// Strobes are decoded from the state; only the absorb strobe/block also follow the handshake.
module ascon_hash_ctrl
  import ascon_pkg::*;
#(
  parameter int BW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [BW-1:0] msg_data,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  output logic          dp_init,
  output logic          dp_absorb,
  output logic [BW-1:0] dp_block,
  output logic          perm_start,
  input  logic          perm_done,
  output logic          tag_we,
  output logic [1:0]    tag_sel,
  output logic          busy,
  output logic          hash_done
);

  state_t     state_q, state_d;
  phase_t     ph_q, ph_d;
  logic [1:0] sq_q, sq_d;

  logic          hs;
  logic          last_full;
  logic [BW-1:0] pad_blk;

  ascon_pad #(.BW(BW)) u_pad (
    .msg_data  (msg_data),
    .msg_last  (msg_last),
    .msg_bytes (msg_bytes),
    .dp_block  (pad_blk)
  );

  assign hs        = msg_valid && (state_q == ST_ABSORB);
  assign last_full = (sat_bytes(msg_bytes) == ASCON_LANE_BYTES);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    sq_d    = sq_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        ph_d    = PH_ABS;
        sq_d    = 2'd0;
        state_d = ST_PSTART;
      end
      ST_PSTART: state_d = ST_WAIT;
      ST_WAIT: begin
        if (perm_done) state_d = (ph_q == PH_ABS) ? ST_ABSORB : ST_SQUEEZE;
      end
      ST_ABSORB: begin
        if (hs) begin
          if (!msg_last) begin
            state_d = ST_PSTART;
          end else if (last_full) begin
            // A full final block still needs a separate lone pad byte.
            state_d = ST_PAD;
          end else begin
            ph_d    = PH_SQZ;
            state_d = ST_PSTART;
          end
        end
      end
      ST_PAD: begin
        ph_d    = PH_SQZ;
        state_d = ST_PSTART;
      end
      ST_SQUEEZE: begin
        if (sq_q == 2'(ASCON_TAG_LANES - 1)) begin
          state_d = ST_DONE;
        end else begin
          sq_d    = sq_q + 2'd1;
          state_d = ST_PSTART;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= PH_ABS;
      sq_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sq_q    <= sq_d;
    end
  end

  assign msg_ready  = (state_q == ST_ABSORB);
  assign dp_init    = (state_q == ST_INIT);
  assign dp_absorb  = hs || (state_q == ST_PAD);
  assign perm_start = (state_q == ST_PSTART);
  assign tag_we     = (state_q == ST_SQUEEZE);
  assign tag_sel    = (state_q == ST_SQUEEZE) ? sq_q : 2'd0;
  assign busy       = (state_q != ST_IDLE);
  assign hash_done  = (state_q == ST_DONE);

  always_comb begin
    dp_block = '0;
    if (hs) begin
      dp_block = pad_blk;
    end else if (state_q == ST_PAD) begin
      dp_block = {ASCON_PAD_BYTE, {(BW - 8){1'b0}}};
    end
  end

endmodule
